// File: rtl/riscv_pkg.sv
// Shared RV32 definitions: M-extension multiply opcodes (func3[1:0]) and
// multiply-unit FSM encodings.
package riscv_pkg;

    localparam logic [1:0] MULCTL_MUL    = 2'b00;
    localparam logic [1:0] MULCTL_MULH   = 2'b01;
    localparam logic [1:0] MULCTL_MULHSU = 2'b10;
    localparam logic [1:0] MULCTL_MULHU  = 2'b11;

    typedef enum logic [1:0] {
        MU_IDLE = 2'd0,
        MU_BUSY = 2'd1,
        MU_DONE = 2'd2
    } mu_state_e;

    function automatic logic mulctl_rs1_signed(input logic [1:0] ctl);
        return (ctl == MULCTL_MULH) || (ctl == MULCTL_MULHSU);
    endfunction

    function automatic logic mulctl_rs2_signed(input logic [1:0] ctl);
        return (ctl == MULCTL_MULH);
    endfunction

endpackage

// File: rtl/mul_step.sv
// One shift-add iteration: adds mcand * mplier_bits, shifted left by 'shift',
// into a 2*XLEN accumulator. Purely combinational.
module mul_step #(
    parameter int XLEN = 32,
    parameter int BPC  = 1,
    parameter int SH_W = $clog2(2 * XLEN)
) (
    input  logic [2*XLEN-1:0] acc_in,
    input  logic [XLEN-1:0]   mcand,
    input  logic [BPC-1:0]    mplier_bits,
    input  logic [SH_W-1:0]   shift,
    output logic [2*XLEN-1:0] acc_out
);

    logic [2*XLEN-1:0] mcand_ext;
    logic [2*XLEN-1:0] pp [BPC];

    assign mcand_ext = {{XLEN{1'b0}}, mcand};

    // One partial product per retired multiplier bit.
    generate
        for (genvar gi = 0; gi < BPC; gi++) begin : g_pp
            assign pp[gi] = mplier_bits[gi] ? (mcand_ext << (shift + SH_W'(gi)))
                                            : '0;
        end
    endgenerate

    always_comb begin
        acc_out = acc_in;
        for (int i = 0; i < BPC; i++) begin
            acc_out = acc_out + pp[i];
        end
    end

endmodule

// File: rtl/mul_unit.sv
// Iterative RV32M multiplier: shift-add on operand magnitudes, BPC bits per
// cycle, fixed latency, sign fix-up applied while registering the result.
module mul_unit
    import riscv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int BPC  = 1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic            flush,
    input  logic [1:0]      mulctl,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            busy,
    output logic            mul_done,
    output logic [XLEN-1:0] result
);

    localparam int STEPS = XLEN / BPC;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int SH_W  = $clog2(2 * XLEN);

    mu_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   mcand_q, mcand_d;
    logic [XLEN-1:0]   mplier_q, mplier_d;
    logic              neg_q, neg_d;
    logic [1:0]        op_q, op_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              accept;
    logic              rs1_neg, rs2_neg;
    logic [XLEN-1:0]   rs1_mag, rs2_mag;
    logic [CNT_W-1:0]  step_idx;
    logic [SH_W-1:0]   step_shift;
    logic [2*XLEN-1:0] acc_step;
    logic [2*XLEN-1:0] prod;

    // Only operands treated as signed contribute a sign; -2^(XLEN-1) maps to
    // 2^(XLEN-1), which still fits as an unsigned XLEN magnitude.
    assign rs1_neg = mulctl_rs1_signed(mulctl) & rs1[XLEN-1];
    assign rs2_neg = mulctl_rs2_signed(mulctl) & rs2[XLEN-1];
    assign rs1_mag = rs1_neg ? -rs1 : rs1;
    assign rs2_mag = rs2_neg ? -rs2 : rs2;

    assign step_idx   = CNT_W'(STEPS - 1) - cnt_q;
    assign step_shift = SH_W'(step_idx) * SH_W'(BPC);

    mul_step #(
        .XLEN (XLEN),
        .BPC  (BPC),
        .SH_W (SH_W)
    ) u_step (
        .acc_in      (acc_q),
        .mcand       (mcand_q),
        .mplier_bits (mplier_q[BPC-1:0]),
        .shift       (step_shift),
        .acc_out     (acc_step)
    );

    // Final product including the last step, so the result lands with DONE.
    assign prod = neg_q ? -acc_step : acc_step;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        op_d     = op_q;
        acc_d    = acc_q;
        result_d = result_q;
        accept   = 1'b0;

        if (flush) begin
            state_d = MU_IDLE;
        end else begin
            unique case (state_q)
                MU_IDLE: begin
                    accept = start;
                end
                MU_BUSY: begin
                    acc_d    = acc_step;
                    mplier_d = mplier_q >> BPC;
                    if (cnt_q == '0) begin
                        state_d  = MU_DONE;
                        result_d = (op_q == MULCTL_MUL) ? prod[XLEN-1:0]
                                                        : prod[2*XLEN-1:XLEN];
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                MU_DONE: begin
                    accept = start;
                    if (!start) begin
                        state_d = MU_IDLE;
                    end
                end
                default: begin
                    state_d = MU_IDLE;
                end
            endcase

            if (accept) begin
                state_d  = MU_BUSY;
                mcand_d  = rs1_mag;
                mplier_d = rs2_mag;
                neg_d    = rs1_neg ^ rs2_neg;
                op_d     = mulctl;
                acc_d    = '0;
                cnt_d    = CNT_W'(STEPS - 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= MU_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            op_q     <= MULCTL_MUL;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    assign busy     = (state_q == MU_BUSY);
    assign mul_done = (state_q == MU_DONE);
    assign result   = result_q;

endmodule

// File: tb/tb_mul_unit.sv
// Scoreboard bench for mul_unit: the driver predicts each accepted operation
// from full-width arithmetic; an independent monitor checks every done pulse.
module tb_mul_unit;

    localparam int LAT = 33;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic        flush;
    logic [1:0]  mulctl;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        busy;
    logic        mul_done;
    logic [31:0] result;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          done_cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          free_at = 0;
    int          busy_lo = 1;
    int          busy_hi = 0;
    logic [31:0] last_result = '0;
    logic        mon_en = 1'b0;

    mul_unit #(.XLEN(32), .BPC(1)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .start    (start),
        .flush    (flush),
        .mulctl   (mulctl),
        .rs1      (rs1),
        .rs2      (rs2),
        .busy     (busy),
        .mul_done (mul_done),
        .result   (result)
    );

    always #5 clk = ~clk;

    always @(negedge clk) cyc <= cyc + 1;

    // Reference: extend each operand per its signedness, take the 64-bit product.
    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] ax, bx, p;
        ax = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
        bx = (op == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
        p  = ax * bx;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Call just after a negedge; the model decides whether the DUT will accept.
    task automatic drive_start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        start  = 1'b1;
        flush  = 1'b0;
        mulctl = op;
        rs1    = a;
        rs2    = b;
        if (cyc >= free_at) begin
            e.op       = op;
            e.a        = a;
            e.b        = b;
            e.res      = ref_mul(op, a, b);
            e.done_cyc = cyc + LAT;
            sb_q.push_back(e);
            free_at = cyc + LAT;
            busy_lo = cyc + 1;
            busy_hi = cyc + LAT - 1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            start  = 1'b0;
            flush  = 1'b0;
            mulctl = 2'($urandom);
            rs1    = $urandom;
            rs2    = $urandom;
        end
    endtask

    // Flush with a competing start; afterwards the old result must be held.
    task automatic do_flush();
        @(negedge clk);
        flush  = 1'b1;
        start  = 1'b1;
        mulctl = 2'b00;
        rs1    = $urandom;
        rs2    = $urandom;
        if (sb_q.size() > 0 && sb_q[$].done_cyc > cyc) void'(sb_q.pop_back());
        if (busy_hi > cyc) busy_hi = cyc;
        free_at = cyc + 1;
        $display("flush at cycle %0d", cyc);
        @(negedge clk);
        flush = 1'b0;
        start = 1'b0;
        check("result_held_after_flush", result, last_result);
    endtask

    // Monitor: busy window every cycle, and every done pulse against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                check("busy", {31'b0, busy}, {31'b0, (cyc >= busy_lo && cyc <= busy_hi)});
                if (mul_done === 1'b1) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_done: got mul_done=1 at cycle %0d, required 0", cyc);
                    end else begin
                        e = sb_q.pop_front();
                        check("result", result, e.res);
                        check("done_cycle", 32'(cyc), 32'(e.done_cyc));
                        $display("done op=%0d rs1=%h rs2=%h result=%h cycle=%0d",
                                 e.op, e.a, e.b, result, cyc);
                        last_result = result;
                    end
                end else begin
                    check("mul_done_low", {31'b0, mul_done}, 32'd0);
                end
            end
        end
    end

    initial begin
        logic [31:0] a, b;
        rstn = 1'b0; start = 1'b0; flush = 1'b0;
        mulctl = 2'b00; rs1 = '0; rs2 = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, mul_done}, 32'd0);
        check("reset_result", result, 32'd0);
        rstn   = 1'b1;
        mon_en = 1'b1;

        // Directed cases
        @(negedge clk); drive_start(2'b00, 32'd7, 32'd6);                idle(34);
        @(negedge clk); drive_start(2'b01, 32'h8000_0000, 32'h8000_0000); idle(34);
        @(negedge clk); drive_start(2'b00, 32'h8000_0000, 32'h8000_0000); idle(34);
        @(negedge clk); drive_start(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF); idle(34);
        @(negedge clk); drive_start(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF); idle(34);
        @(negedge clk); drive_start(2'b00, 32'd0, 32'd0);                idle(34);

        // Flush mid-operation, then a new op the following cycle
        @(negedge clk); drive_start(2'b01, 32'h1234_5678, 32'h9ABC_DEF0);
        idle(9);
        do_flush();
        drive_start(2'b00, 32'd3, 32'd5);
        idle(36);

        // Start held high through BUSY and DONE: back-to-back 2*3 then 4*5
        for (int i = 0; i <= LAT; i++) begin
            @(negedge clk);
            if (i == 0)        drive_start(2'b00, 32'd2, 32'd3);
            else if (i == LAT) drive_start(2'b00, 32'd4, 32'd5);
            else               drive_start(2'b11, 32'd9, 32'd9);
        end
        idle(36);

        // Randomized operations, gaps and flushes
        for (int n = 0; n < 30; n++) begin
            a = pick();
            b = pick();
            @(negedge clk);
            drive_start(2'($urandom_range(0, 3)), a, b);
            if ($urandom_range(0, 5) == 0) begin
                idle($urandom_range(1, 30));
                do_flush();
            end else begin
                idle($urandom_range(30, 36));
            end
        end
        idle(36);

        // Reset mid-BUSY discards the operation
        @(negedge clk); drive_start(2'b01, 32'hDEAD_BEEF, 32'h0BAD_F00D);
        idle(8);
        @(negedge clk);
        rstn  = 1'b0;
        start = 1'b0;
        sb_q.delete();
        if (busy_hi > cyc) busy_hi = cyc;
        free_at = cyc + 1;
        $display("reset at cycle %0d", cyc);
        @(negedge clk);
        check("midreset_busy", {31'b0, busy}, 32'd0);
        check("midreset_done", {31'b0, mul_done}, 32'd0);
        check("midreset_result", result, 32'd0);
        last_result = '0;
        rstn = 1'b1;
        idle(40);

        @(negedge clk); drive_start(2'b10, 32'h8000_0000, 32'hFFFF_FFFF); idle(36);

        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL pending_ops: got %0d outstanding operations, required 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
